// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with control/data registers
`timescale 1ns/1ps
module spi_master_param #(
  parameter int REG_W  = 32,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              clkfast,
  input  logic              rst,
  input  logic              RegSel,
  input  logic              WR,
  input  logic [REG_W-1:0]  DatosIN,
  output logic [REG_W-1:0]  SalidaMUX,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SS,
  output logic              IRQ
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t state, state_nxt;

  localparam logic [4:0] LEN_MAX = 5'(REG_W - 1);

  logic [DIV_W-1:0]  div, cnt;
  logic              cpol, cpha, lsb_first, done;
  logic [4:0]        lenm1, len_in;
  logic [2:0]        ss_idx;
  logic [5:0]        ecnt;
  logic [REG_W-1:0]  data;
  logic [31:0]       wr32, rd32, dext, lmask, shifted;
  logic [NUM_SS-1:0] ss_sel;
  logic busy, tick, wr_ok, start_acc, shift_edge, last_edge, sample, drive, finish;
  logic unused_bits;

  // Control fields are decoded from a 32-bit view so narrow REG_W still elaborates.
  always_comb begin
    wr32 = '0;
    wr32[REG_W-1:0] = DatosIN;
    dext = '0;
    dext[REG_W-1:0] = data;
  end

  assign len_in    = (wr32[20:16] > LEN_MAX) ? LEN_MAX : wr32[20:16];
  assign lmask     = 32'hFFFF_FFFF >> (5'd31 - lenm1);
  assign wr_ok     = WR && !busy;
  assign start_acc = wr_ok && !RegSel && wr32[0];

  always_comb begin
    for (int i = 0; i < NUM_SS; i++) ss_sel[i] = (wr32[26:24] != 3'(i));
  end

  // Received bit enters at bit 0 (MSB-first) or at bit LEN-1 (LSB-first).
  always_comb begin
    if (lsb_first) begin
      shifted = (dext >> 1) & (lmask >> 1);
      shifted[lenm1] = MISO;
    end else begin
      shifted = ((dext << 1) | {31'b0, MISO}) & lmask;
    end
  end

  always_ff @(posedge clkfast or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc)        state_nxt = LEAD;
      LEAD:    if (tick)             state_nxt = SHIFT;
      SHIFT:   if (tick && last_edge) state_nxt = TRAIL;
      TRAIL:   if (tick)             state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // ecnt holds edges already made, so ecnt[0]==0 means the coming edge is odd.
  always_comb begin
    busy       = (state != IDLE);
    tick       = (cnt == div);
    shift_edge = (state == SHIFT) && tick;
    last_edge  = (ecnt == {lenm1, 1'b1});
    sample     = shift_edge && (ecnt[0] == cpha);
    drive      = shift_edge && (ecnt[0] != cpha) && !last_edge;
    finish     = (state == TRAIL) && tick;
  end

  always_ff @(posedge clkfast or negedge rst) begin
    if (!rst) begin
      cnt <= '0; div <= '0; cpol <= 1'b0; cpha <= 1'b0; lsb_first <= 1'b0;
      lenm1 <= '0; ss_idx <= '0; done <= 1'b0; ecnt <= '0; data <= '0;
      MOSI <= 1'b0; SCLK <= 1'b0; SS <= '1; IRQ <= 1'b0;
    end else begin
      IRQ <= finish;
      if (busy) cnt <= tick ? '0 : cnt + 1'b1;
      else      cnt <= '0;

      if (wr_ok && !RegSel) begin
        cpol      <= wr32[3];
        cpha      <= wr32[4];
        lsb_first <= wr32[5];
        div       <= wr32[8 +: DIV_W];
        lenm1     <= len_in;
        ss_idx    <= wr32[26:24];
        done      <= 1'b0;
        SCLK      <= wr32[3];
      end else if (!busy) begin
        SCLK <= cpol;
      end else if (shift_edge) begin
        SCLK <= ~SCLK;
      end

      if (start_acc) begin
        SS   <= ss_sel;
        MOSI <= wr32[5] ? dext[0] : dext[len_in];
        ecnt <= '0;
      end
      if (shift_edge) ecnt <= ecnt + 1'b1;
      if (drive) MOSI <= lsb_first ? dext[0] : dext[lenm1];

      if (wr_ok && RegSel) data <= DatosIN;
      else if (sample)     data <= shifted[REG_W-1:0];

      if (finish) begin
        SS   <= '1;
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    rd32 = '0;
    rd32[1] = busy;
    rd32[2] = done;
    rd32[3] = cpol;
    rd32[4] = cpha;
    rd32[5] = lsb_first;
    rd32[8 +: DIV_W] = div;
    rd32[20:16] = lenm1;
    rd32[26:24] = ss_idx;
    SalidaMUX = RegSel ? data : rd32[REG_W-1:0];
  end

  assign unused_bits = ^{wr32, shifted, rd32};

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed self-checking bench for spi_master_param
`timescale 1ns/1ps
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, regsel, wr;
  logic [31:0] din, dout_a, dout;
  logic [23:0] dout_b;
  logic        miso_a, mosi_a, sclk_a, irq_a;
  logic        mosi_b, sclk_b, irq_b;
  logic [3:0]  ss_a, ss_b;
  int          tgt;
  int          miso_mode;
  logic        miso_const;
  logic [31:0] slave_tx;
  logic        mon_cpha;
  logic        slave_bit;

  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;

  spi_master_param #(.REG_W(32), .NUM_SS(4), .DIV_W(8)) u_dut (
    .clkfast(clk), .rst(rst_n), .RegSel(regsel), .WR(wr && tgt == 0),
    .DatosIN(din), .SalidaMUX(dout_a), .MISO(miso_a), .MOSI(mosi_a),
    .SCLK(sclk_a), .SS(ss_a), .IRQ(irq_a));

  spi_master_param #(.REG_W(24), .NUM_SS(4), .DIV_W(8)) u_dut24 (
    .clkfast(clk), .rst(rst_n), .RegSel(regsel), .WR(wr && tgt == 1),
    .DatosIN(din[23:0]), .SalidaMUX(dout_b), .MISO(mosi_b), .MOSI(mosi_b),
    .SCLK(sclk_b), .SS(ss_b), .IRQ(irq_b));

  assign dout = (tgt == 1) ? {8'h00, dout_b} : dout_a;

  // Monitor / SPI slave model on the 32-bit instance
  int          clr_req = 0, clr_ack = 0;
  int          edge_no, launch_cnt, gap, gap_min, gap_max, irq_cnt;
  logic [31:0] slave_rx;
  logic [3:0]  ss_and;
  logic        sclk_prev;

  always_comb begin
    int idx;
    idx = mon_cpha ? ((launch_cnt == 0) ? 0 : launch_cnt - 1) : launch_cnt;
    slave_bit = (idx < 32) ? slave_tx[31 - idx] : 1'b0;
    case (miso_mode)
      0:       miso_a = mosi_a;
      1:       miso_a = miso_const;
      default: miso_a = slave_bit;
    endcase
  end

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      edge_no = 0; launch_cnt = 0; gap = 0; gap_min = 1000; gap_max = 0;
      irq_cnt = 0; slave_rx = 0; ss_and = 4'hF;
    end else begin
      gap++;
      if (rst_n && sclk_a !== sclk_prev) begin
        edge_no++;
        if (edge_no > 1) begin
          if (gap < gap_min) gap_min = gap;
          if (gap > gap_max) gap_max = gap;
        end
        gap = 0;
        if ((edge_no % 2 == 1) ^ mon_cpha) slave_rx = {slave_rx[30:0], mosi_a};
        else launch_cnt++;
      end
      if (irq_a) irq_cnt++;
      ss_and = ss_and & ss_a;
    end
    sclk_prev = sclk_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input int t, input logic sel, input logic [31:0] v);
    tgt = t; regsel = sel; din = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; regsel = 1'b0;
  endtask

  task automatic rd(input int t, input logic sel, output logic [31:0] v);
    tgt = t; regsel = sel;
    #1 v = dout;
    regsel = 1'b0;
    #1;
  endtask

  task automatic clear_mon();
    clr_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    regsel = 1'b0;
    n = 1;
    while (dout[1] === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Config write first so an idle SCLK level change is not seen as an edge.
  task automatic run(input int t, input logic [31:0] ctrl, output int lat);
    wr_reg(t, 1'b0, ctrl & ~32'h1);
    clear_mon();
    wr_reg(t, 1'b0, ctrl);
    wait_idle(lat);
  endtask

  int          lat;
  logic [31:0] v;

  initial begin
    rst_n = 1'b0; regsel = 1'b0; wr = 1'b0; din = '0; tgt = 0;
    miso_mode = 0; miso_const = 1'b0; slave_tx = '0; mon_cpha = 1'b0;
    repeat (3) @(negedge clk);
    rd(0, 1'b0, v); chk("rst_ctrl", v, 32'h0);
    rd(0, 1'b1, v); chk("rst_data", v, 32'h0);
    chk("rst_ss", ss_a, 4'hF);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_mosi", mosi_a, 1'b0);
    chk("rst_irq", irq_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: mode 0, MSB-first, DIV=1, LEN=8, SS_IDX=2, loopback
    wr_reg(0, 1'b1, 32'h0000_00A5);
    miso_mode = 0; mon_cpha = 1'b0;
    run(0, 32'h0207_0101, lat);
    chk("t1_latency", lat, 37);
    chk("t1_mosi_bits", slave_rx, 32'h0000_00A5);
    rd(0, 1'b1, v); chk("t1_data", v, 32'h0000_00A5);
    chk("t1_irq", irq_cnt, 1);
    chk("t1_ss_low", ss_and, 4'hB);
    chk("t1_edges", edge_no, 16);
    chk("t1_ss_end", ss_a, 4'hF);
    rd(0, 1'b0, v); chk("t1_ctrl", v, 32'h0207_0104);

    // 2: mode 3, LSB-first, DIV=0, LEN=12, MISO tied 1
    wr_reg(0, 1'b1, 32'h0000_0ABC);
    miso_mode = 1; miso_const = 1'b1; mon_cpha = 1'b1;
    run(0, 32'h000B_0039, lat);
    chk("t2_latency", lat, 27);
    chk("t2_mosi_bits", slave_rx, 32'h0000_03D5);
    rd(0, 1'b1, v); chk("t2_data", v, 32'h0000_0FFF);
    rd(0, 1'b0, v); chk("t2_ctrl", v, 32'h000B_003C);
    chk("t2_sclk_idle", sclk_a, 1'b1);
    chk("t2_edges", edge_no, 24);

    // 3a: mode 1, LEN=32, DIV=3, slave returns its previous frame
    wr_reg(0, 1'b1, 32'hDEAD_BEEF);
    miso_mode = 2; mon_cpha = 1'b1; slave_tx = 32'h1234_5678;
    run(0, 32'h011F_0311, lat);
    chk("t3a_latency", lat, 265);
    rd(0, 1'b1, v); chk("t3a_data", v, 32'h1234_5678);
    chk("t3a_slave_rx", slave_rx, 32'hDEAD_BEEF);
    chk("t3a_edges", edge_no, 64);
    chk("t3a_gap_min", gap_min, 4);
    chk("t3a_gap_max", gap_max, 4);
    chk("t3a_ss_low", ss_and, 4'hD);

    // 3b: mode 2
    wr_reg(0, 1'b1, 32'hDEAD_BEEF);
    mon_cpha = 1'b0; slave_tx = 32'hDEAD_BEEF;
    run(0, 32'h011F_0309, lat);
    chk("t3b_latency", lat, 265);
    rd(0, 1'b1, v); chk("t3b_data", v, 32'hDEAD_BEEF);
    chk("t3b_slave_rx", slave_rx, 32'hDEAD_BEEF);
    chk("t3b_edges", edge_no, 64);
    chk("t3b_gap_max", gap_max, 4);
    chk("t3b_sclk_idle", sclk_a, 1'b1);

    // 4: writes during BUSY are ignored
    wr_reg(0, 1'b1, 32'h0000_5A5A);
    miso_mode = 0; mon_cpha = 1'b0;
    wr_reg(0, 1'b0, 32'h000F_0000);
    clear_mon();
    wr_reg(0, 1'b0, 32'h000F_0001);
    repeat (4) @(negedge clk);
    wr_reg(0, 1'b1, 32'h0000_1234);
    wr_reg(0, 1'b0, 32'h0303_0001);
    wait_idle(lat);
    chk("t4_timeout", lat < 3000, 1'b1);
    rd(0, 1'b1, v); chk("t4_data", v, 32'h0000_5A5A);
    rd(0, 1'b0, v); chk("t4_ctrl", v, 32'h000F_0004);
    chk("t4_edges", edge_no, 32);
    chk("t4_irq", irq_cnt, 1);
    chk("t4_ss_low", ss_and, 4'hE);

    // 5: reset during SHIFT of a LEN=16 transfer
    wr_reg(0, 1'b1, 32'h0000_FFFF);
    miso_mode = 1; miso_const = 1'b1;
    wr_reg(0, 1'b0, 32'h010F_0108);
    clear_mon();
    wr_reg(0, 1'b0, 32'h010F_0109);
    repeat (10) @(negedge clk);
    chk("t5_mosi_pre", mosi_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_ss", ss_a, 4'hF);
    chk("t5_sclk", sclk_a, 1'b0);
    chk("t5_mosi", mosi_a, 1'b0);
    rd(0, 1'b0, v); chk("t5_ctrl", v, 32'h0);
    rd(0, 1'b1, v); chk("t5_data", v, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_no_irq", irq_cnt, 0);
    chk("t5_ss_after", ss_a, 4'hF);

    // 6a: LEN-1=31 on a 24-bit instance clamps to a 24-bit transfer
    wr_reg(1, 1'b1, 32'h00C3_A55A);
    run(1, 32'h001F_0001, lat);
    chk("t6a_latency", lat, 51);
    rd(1, 1'b1, v); chk("t6a_data", v, 32'h00C3_A55A);
    rd(1, 1'b0, v); chk("t6a_ctrl", v, 32'h0017_0004);
    chk("t6a_ss", ss_b, 4'hF);

    // 6b: SS_IDX=7 with NUM_SS=4 selects no line but still transfers
    wr_reg(0, 1'b1, 32'h0000_003C);
    miso_mode = 0; mon_cpha = 1'b0;
    run(0, 32'h0707_0001, lat);
    chk("t6b_latency", lat, 19);
    chk("t6b_ss_none", ss_and, 4'hF);
    rd(0, 1'b1, v); chk("t6b_data", v, 32'h0000_003C);
    rd(0, 1'b0, v); chk("t6b_ctrl", v, 32'h0707_0004);
    chk("t6b_irq", irq_cnt, 1);
    chk("t6b_edges", edge_no, 16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
